// File: rtl/dtt_pkg.sv
// Shared types and helpers for the digital-to-time transmitter and its frame timing.
package dtt_pkg;

  typedef enum logic [1:0] {DTT_IDLE, DTT_ARMED, DTT_FIRED} dtt_state_t;

  function automatic int unsigned code_width(input int unsigned width);
    return width - 1;
  endfunction

  // Inverse of the receiver capture: flip the code MSB to get the in-frame count.
  function automatic logic [31:0] code_to_target(input logic [31:0] code,
                                                 input int unsigned code_w);
    return code ^ (32'd1 << (code_w - 1));
  endfunction

endpackage

// File: rtl/dtt_edge_gen_frame_counter.sv
// Free-running down counter shared by transmitter and receiver; MSB is the capacitor-reset phase.
module frame_counter #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             phase
);

  always_ff @(posedge clk) begin
    if (rst) count <= '1;
    else     count <= count - WIDTH'(1);
  end

  assign phase = count[WIDTH-1];

endmodule

// File: rtl/dtt_edge_gen.sv
// Digital-to-time transmitter: one edge per armed frame at the code's capture position.
// Optional DTT_REPEAT_EN: re-arm with the previous code when no fresh code is pending.
module dtt_edge_gen
  import dtt_pkg::*;
#(
  parameter  int unsigned WIDTH  = 9,
  localparam int unsigned CODE_W = code_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              rst_cap,
  output logic              edge_out,
  output logic              done
);

  logic [WIDTH-1:0]  count;
  logic [WIDTH-1:0]  count_nx;
  logic              phase;
  dtt_state_t        state, state_nx;
  logic [CODE_W-1:0] pending_code, active_code, active_nx;
  logic [CODE_W-1:0] target, target_nx;
  logic              pending_valid, pend_take;
  logic              have_code, have_nx;
  logic              meas_start, wrap;

  frame_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .phase (phase)
  );

  // Arming and edge decisions look one count ahead so edge_out can be registered.
  assign count_nx   = count - WIDTH'(1);
  assign meas_start = (count_nx == {1'b0, {CODE_W{1'b1}}});
  assign wrap       = (count == '0);
  assign target     = CODE_W'(code_to_target(32'(active_code), CODE_W));
  assign target_nx  = CODE_W'(code_to_target(32'(active_nx), CODE_W));

  always_comb begin
    state_nx  = state;
    active_nx = active_code;
    have_nx   = have_code;
    pend_take = 1'b0;
    if (wrap) begin
      state_nx = DTT_IDLE;
    end else if (meas_start) begin
      if (pending_valid) begin
        state_nx  = DTT_ARMED;
        active_nx = pending_code;
        have_nx   = 1'b1;
        pend_take = 1'b1;
      end
`ifdef DTT_REPEAT_EN
      else if (have_code) begin
        state_nx = DTT_ARMED;
      end
`endif
      else begin
        state_nx = DTT_IDLE;
      end
    end else if (state == DTT_ARMED && !phase && count[CODE_W-1:0] == target) begin
      state_nx = DTT_FIRED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DTT_IDLE;
      pending_code  <= '0;
      pending_valid <= 1'b0;
      active_code   <= '0;
      have_code     <= 1'b0;
      edge_out      <= 1'b0;
      done          <= 1'b0;
    end else begin
      state       <= state_nx;
      active_code <= active_nx;
      have_code   <= have_nx;
      if (code_valid && code_ready) begin
        pending_code  <= code_in;
        pending_valid <= 1'b1;
      end else if (pend_take) begin
        pending_valid <= 1'b0;
      end
      edge_out <= !count_nx[WIDTH-1] && (state_nx != DTT_IDLE) &&
                  (count_nx[CODE_W-1:0] <= target_nx);
      // Every armed frame reaches its target before the wrap, so ARMED here means fired.
      done     <= wrap && (state != DTT_IDLE);
    end
  end

  assign code_ready = !pending_valid;
  assign rst_cap    = phase;

endmodule

// File: tb/tb_dtt_edge_gen.sv
// Self-checking bench for dtt_edge_gen against a frame-level reference model.
module tb_dtt_edge_gen;

  localparam int unsigned WIDTH = 9;
`ifdef DTT_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code_in = '0;
  logic       code_ready, rst_cap, edge_out, done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: frame position, pending slot, whether this frame carries a code, last frame armed.
  logic [8:0] m_cnt = 9'd511;
  bit         m_pv = 0, m_arm = 0, m_have = 0, m_last = 0;
  logic [7:0] m_pc = '0, m_code = '0;

  always #5 clk = ~clk;

  dtt_edge_gen #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .rst_cap    (rst_cap),
    .edge_out   (edge_out),
    .done       (done)
  );

  // {rst_cap, edge_out, done, code_ready} expected for the current cycle.
  function automatic logic [3:0] exp_vec();
    logic [7:0] tgt;
    tgt = m_code ^ 8'h80;
    return {m_cnt >= 9'd256,
            (m_cnt < 9'd256) && m_arm && (m_cnt[7:0] <= tgt),
            (m_cnt == 9'd511) && m_last,
            !m_pv};
  endfunction

  task automatic tick(input bit r, input bit v, input logic [7:0] c);
    bit         xfer;
    logic [8:0] nc;
    rst = r; code_valid = v; code_in = c;
    xfer = v && !m_pv && !r;
    if (r) begin
      m_cnt = 9'd511; m_pv = 0; m_arm = 0; m_have = 0; m_last = 0;
    end else begin
      nc = m_cnt - 9'd1;
      if (nc == 9'd255) begin
        if (m_pv) begin
          m_arm = 1; m_code = m_pc; m_pv = 0; m_have = 1;
        end else begin
          m_arm = REPEAT && m_have;
        end
      end
      if (nc == 9'd511) begin
        m_last = m_arm; m_arm = 0;
      end
      if (xfer) begin
        m_pv = 1; m_pc = c;
      end
      m_cnt = nc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic align(input logic [8:0] t);
    for (int i = 0; i < 600 && m_cnt != t; i++) tick(0, 0, 8'h00);
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    tick(1, 0, 8'h00);
    tick(1, 0, 8'h00);
    obs = {rst_cap, edge_out, done, code_ready};
    checks++;
    if (obs !== 4'b1001) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", obs, 4'b1001);
    end
  endtask

  task automatic test_single_code(input logic [7:0] code, input int unsigned exp_edges);
    logic [3:0]  obs;
    int unsigned edges = 0, dones = 0;
    align(9'd300);
    tick(0, 1, code);
    for (int i = 0; i < 330; i++) begin
      obs = {rst_cap, edge_out, done, code_ready};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL single_%h_vec cnt=%0d got=%b exp=%b", code, m_cnt, obs, exp_vec());
      end
      edges += int'(edge_out);
      dones += int'(done);
      tick(0, 0, 8'h00);
    end
    checks++;
    if (edges != exp_edges) begin
      errors++;
      $display("FAIL single_%h_width got=%0d exp=%0d", code, edges, exp_edges);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL single_%h_done got=%0d exp=1", code, dones);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] codes [4];
    logic [7:0] rec;
    logic [3:0] obs;
    logic       prev;
    int unsigned rises;
    codes[0] = 8'h00; codes[1] = 8'h55; codes[2] = 8'hAA; codes[3] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      align(9'd300);
      tick(0, 1, codes[k]);
      prev = edge_out;
      rises = 0;
      for (int i = 0; i < 330; i++) begin
        obs = {rst_cap, edge_out, done, code_ready};
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL loopback_vec cnt=%0d got=%b exp=%b", m_cnt, obs, exp_vec());
        end
        if (!prev && edge_out) begin
          rises++;
          rec = {~m_cnt[7], m_cnt[6:0]};
          checks++;
          if (rec !== codes[k]) begin
            errors++;
            $display("FAIL loopback_code got=%h exp=%h", rec, codes[k]);
          end
        end
        prev = edge_out;
        tick(0, 0, 8'h00);
      end
      checks++;
      if (rises != 1) begin
        errors++;
        $display("FAIL loopback_rises code=%h got=%0d exp=1", codes[k], rises);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  codes [2];
    logic [3:0]  obs;
    logic        prev;
    bit          v, seen;
    logic [7:0]  c;
    int unsigned idx = 0, rises = 0, dones = 0;
    codes[0] = 8'h10; codes[1] = 8'h20;
    align(9'd300);
    prev = edge_out;
    for (int i = 0; i < 830; i++) begin
      obs = {rst_cap, edge_out, done, code_ready};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_vec cnt=%0d got=%b exp=%b", m_cnt, obs, exp_vec());
      end
      if (!prev && edge_out) rises++;
      dones += int'(done);
      prev = edge_out;
      v = (idx < 2);
      c = v ? codes[idx] : 8'h00;
      if (v && !m_pv) idx++;
      tick(0, v, c);
    end
    checks++;
    if (rises != 2 || dones != 2 || idx != 2) begin
      errors++;
      $display("FAIL b2b_counts rises=%0d dones=%0d accepted=%0d exp=2/2/2", rises, dones, idx);
    end
    // Reset while the edge is high.
    tick(0, 1, 8'h33);
    seen = 0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      if (edge_out) seen = 1;
      else tick(0, 0, 8'h00);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_wait_edge got=timeout exp=edge_out high");
    end
    tick(1, 0, 8'h00);
    checks++;
    if (edge_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop got=%b exp=0", edge_out);
    end
    rises = 0;
    prev = edge_out;
    for (int i = 0; i < 1100; i++) begin
      tick(0, 0, 8'h00);
      obs = {rst_cap, edge_out, done, code_ready};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL post_rst_vec cnt=%0d got=%b exp=%b", m_cnt, obs, exp_vec());
      end
      if (!prev && edge_out) rises++;
      prev = edge_out;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL post_rst_rises got=%0d exp=0", rises);
    end
  endtask

  task automatic test_repeat();
    logic [3:0]  obs;
    logic        prev;
    int unsigned rises = 0, dones = 0, exp_n;
    exp_n = REPEAT ? 3 : 1;
    align(9'd300);
    tick(0, 1, 8'h40);
    prev = edge_out;
    for (int i = 0; i < 1334; i++) begin
      obs = {rst_cap, edge_out, done, code_ready};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL repeat_vec cnt=%0d got=%b exp=%b", m_cnt, obs, exp_vec());
      end
      if (!prev && edge_out) rises++;
      dones += int'(done);
      prev = edge_out;
      tick(0, 0, 8'h00);
    end
    checks++;
    if (rises != exp_n || dones != exp_n) begin
      errors++;
      $display("FAIL repeat_counts rises=%0d dones=%0d exp=%0d", rises, dones, exp_n);
    end
  endtask

  task automatic test_random();
    logic [3:0] obs;
    bit         r, v;
    logic [7:0] c;
    for (int i = 0; i < 3000; i++) begin
      obs = {rst_cap, edge_out, done, code_ready};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_vec i=%0d cnt=%0d got=%b exp=%b", i, m_cnt, obs, exp_vec());
      end
      r = ($urandom_range(0, 999) == 0);
      v = ($urandom_range(0, 3) == 0);
      c = 8'($urandom);
      tick(r, v, c);
    end
  endtask

  initial begin
    test_reset();
    test_single_code(8'h80, 1);
    test_single_code(8'h7F, 256);
    test_loopback();
    test_back_to_back();
    test_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
